// File: rtl/hyper_eot_classifier.sv
`default_nettype none
// ============================================================================
// Module   : hyper_eot_classifier
// Purpose  : Tracks the direction of each issued HyperBus transfer in an
//            in-order 1-bit FIFO and converts every end-of-transfer pulse
//            into a dedicated read-done or write-done event.
// Revision : 1.0 - initial release
// ============================================================================
module hyper_eot_classifier #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             sys_clk_i,
   input  logic             rstn_i,
   input  logic             clr_i,
   input  logic             rx_issue_i,
   input  logic             tx_issue_i,
   input  logic             eot_i,
   input  logic             err_clr_i,
   output logic             rd_done_o,
   output logic             wr_done_o,
   output logic [CNT_W-1:0] pending_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             err_ovf_o,
   output logic             err_unf_o
);

   localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

   // Entry encoding: 1 = read, 0 = write.
   logic [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_rd_done;
   logic             r_wr_done;
   logic             r_err_ovf;
   logic             r_err_unf;

   logic             w_pop;
   logic [CNT_W-1:0] w_space;
   logic             w_push_rd;
   logic             w_push_wr;
   logic [PTR_W-1:0] w_wr_slot;
   logic             w_ovf_set;
   logic             w_unf_set;
   logic             w_head;

   // Pop first, then admit pushes against the space the pop frees up;
   // a flush cycle ignores every other input, including error detection.
   always_comb begin
      w_head    = r_mem[r_rd_ptr];
      w_pop     = !clr_i && eot_i && (r_count != '0);
      w_space   = c_depth - r_count + CNT_W'(w_pop);
      w_push_rd = !clr_i && rx_issue_i && (w_space >= CNT_W'(1));
      // A same-cycle read is older, so the write needs a second free slot.
      w_push_wr = !clr_i && tx_issue_i &&
                  (rx_issue_i ? (w_space >= CNT_W'(2)) : (w_space >= CNT_W'(1)));
      w_wr_slot = r_wr_ptr + PTR_W'(w_push_rd);
      w_ovf_set = !clr_i && ((rx_issue_i && !w_push_rd) || (tx_issue_i && !w_push_wr));
      w_unf_set = !clr_i && eot_i && (r_count == '0);
   end

   // Direction storage; contents are only meaningful between the pointers.
   always_ff @(posedge sys_clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_push_rd && (PTR_W'(i) == r_wr_ptr)) begin
            r_mem[i] <= 1'b1;
         end else if (w_push_wr && (PTR_W'(i) == w_wr_slot)) begin
            r_mem[i] <= 1'b0;
         end
      end
   end

   // Pointers, occupancy and the registered done pulses.
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rd_done <= 1'b0;
         r_wr_done <= 1'b0;
      end else if (clr_i) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rd_done <= 1'b0;
         r_wr_done <= 1'b0;
      end else begin
         r_wr_ptr  <= r_wr_ptr + PTR_W'(w_push_rd) + PTR_W'(w_push_wr);
         r_rd_ptr  <= r_rd_ptr + PTR_W'(w_pop);
         r_count   <= r_count + CNT_W'(w_push_rd) + CNT_W'(w_push_wr) - CNT_W'(w_pop);
         r_rd_done <= w_pop && w_head;
         r_wr_done <= w_pop && !w_head;
      end
   end

   // Sticky error flags: a new error beats a same-cycle clear; flush leaves them alone.
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_err_ovf <= 1'b0;
         r_err_unf <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_err_ovf <= 1'b1;
         end else if (err_clr_i) begin
            r_err_ovf <= 1'b0;
         end
         if (w_unf_set) begin
            r_err_unf <= 1'b1;
         end else if (err_clr_i) begin
            r_err_unf <= 1'b0;
         end
      end
   end

   assign rd_done_o = r_rd_done;
   assign wr_done_o = r_wr_done;
   assign pending_o = r_count;
   assign empty_o   = (r_count == '0);
   assign full_o    = (r_count == c_depth);
   assign err_ovf_o = r_err_ovf;
   assign err_unf_o = r_err_unf;

endmodule
`default_nettype wire

// File: tb/tb_hyper_eot_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyper_eot_classifier
// Purpose  : Directed self-checking bench for hyper_eot_classifier (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyper_eot_classifier;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             sys_clk_i = 1'b0;
   logic             rstn_i    = 1'b0;
   logic             clr_i     = 1'b0;
   logic             rx_issue_i = 1'b0;
   logic             tx_issue_i = 1'b0;
   logic             eot_i     = 1'b0;
   logic             err_clr_i = 1'b0;
   logic             rd_done_o;
   logic             wr_done_o;
   logic [CNT_W-1:0] pending_o;
   logic             empty_o;
   logic             full_o;
   logic             err_ovf_o;
   logic             err_unf_o;

   int n_cmp = 0;
   int n_err = 0;

   hyper_eot_classifier #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .sys_clk_i  (sys_clk_i),
      .rstn_i     (rstn_i),
      .clr_i      (clr_i),
      .rx_issue_i (rx_issue_i),
      .tx_issue_i (tx_issue_i),
      .eot_i      (eot_i),
      .err_clr_i  (err_clr_i),
      .rd_done_o  (rd_done_o),
      .wr_done_o  (wr_done_o),
      .pending_o  (pending_o),
      .empty_o    (empty_o),
      .full_o     (full_o),
      .err_ovf_o  (err_ovf_o),
      .err_unf_o  (err_unf_o)
   );

   // 100 MHz clock
   always #5 sys_clk_i = ~sys_clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full output snapshot: done pulses, occupancy, flags.
   task automatic chk_all(input string tag, input logic rd, input logic wr,
                          input int pend, input logic ovf, input logic unf);
      chk({tag, ".rd_done"}, 32'(rd_done_o), 32'(rd));
      chk({tag, ".wr_done"}, 32'(wr_done_o), 32'(wr));
      chk({tag, ".pending"}, 32'(pending_o), 32'(pend));
      chk({tag, ".empty"},   32'(empty_o),   32'(pend == 0));
      chk({tag, ".full"},    32'(full_o),    32'(pend == DEPTH));
      chk({tag, ".err_ovf"}, 32'(err_ovf_o), 32'(ovf));
      chk({tag, ".err_unf"}, 32'(err_unf_o), 32'(unf));
   endtask

   // Apply one cycle of inputs, step past the edge, then drop all pulses.
   task automatic cyc(input logic rx, input logic tx, input logic eot,
                      input logic clr, input logic eclr);
      rx_issue_i = rx;
      tx_issue_i = tx;
      eot_i      = eot;
      clr_i      = clr;
      err_clr_i  = eclr;
      @(posedge sys_clk_i);
      #1;
      rx_issue_i = 1'b0;
      tx_issue_i = 1'b0;
      eot_i      = 1'b0;
      clr_i      = 1'b0;
      err_clr_i  = 1'b0;
   endtask

   initial begin
      // ---- reset ----
      @(posedge sys_clk_i);
      @(posedge sys_clk_i);
      #1;
      chk_all("reset", 0, 0, 0, 0, 0);
      rstn_i = 1'b1;

      // ---- single read ----
      cyc(1, 0, 0, 0, 0);
      chk_all("single.issue", 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
      chk_all("single.hold", 0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("single.done", 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk_all("single.after", 0, 0, 0, 0, 0);

      // ---- ordered mix R,W,W,R ----
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("mix.pend3", 32'(pending_o), 32'd3);
      cyc(1, 0, 0, 0, 0);
      chk_all("mix.full", 0, 0, 4, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("mix.eot0", 1, 0, 3, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk_all("mix.gap0", 0, 0, 3, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("mix.eot1", 0, 1, 2, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("mix.eot2", 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("mix.eot3", 1, 0, 0, 0, 0);

      // ---- simultaneous issues ----
      cyc(1, 1, 0, 0, 0);
      chk_all("simul.issue", 0, 0, 2, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("simul.eot0", 1, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("simul.eot1", 0, 1, 0, 0, 0);

      // ---- overflow with concurrent pop: queue R,R,W,W ----
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk_all("ovf.full", 0, 0, 4, 0, 0);
      cyc(1, 1, 1, 0, 0);
      chk_all("ovf.hit", 1, 0, 4, 1, 0);
      cyc(0, 0, 0, 0, 1);
      chk_all("ovf.clr", 0, 0, 4, 0, 0);
      // Queue is now R,W,W,R across the pointer wrap; drain back-to-back.
      cyc(0, 0, 1, 0, 0);
      chk_all("ovf.drain0", 1, 0, 3, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("ovf.drain1", 0, 1, 2, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("ovf.drain2", 0, 1, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk_all("ovf.drain3", 1, 0, 0, 0, 0);

      // ---- overflow with no space at all: both dropped ----
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk_all("ovf2.both", 0, 0, 4, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
      chk_all("ovf2.drain", 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 1);
      chk_all("ovf2.clr", 0, 0, 0, 0, 0);

      // ---- underflow ----
      cyc(0, 0, 1, 0, 0);
      chk_all("unf.hit", 0, 0, 0, 0, 1);
      cyc(1, 0, 1, 0, 0);
      chk_all("unf.push", 0, 0, 1, 0, 1);

      // ---- clear with eot ----
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("clr.pend3", 32'(pending_o), 32'd3);
      cyc(0, 0, 1, 1, 0);
      chk_all("clr.hit", 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      chk_all("clr.after", 0, 0, 0, 0, 1);

      // ---- error clear loses to a same-cycle set ----
      cyc(0, 0, 1, 0, 1);
      chk_all("eclr.race", 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk_all("eclr.done", 0, 0, 0, 0, 0);

      // ---- asynchronous reset mid-stream ----
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk_all("rst.pre", 0, 0, 2, 0, 1);
      eot_i = 1'b1;
      @(posedge sys_clk_i);
      #1;
      eot_i = 1'b0;
      chk_all("rst.done", 1, 0, 1, 0, 1);
      #2;
      rstn_i = 1'b0;
      #1;
      chk_all("rst.async", 0, 0, 0, 0, 0);
      @(posedge sys_clk_i);
      #1;
      rstn_i = 1'b1;
      cyc(0, 0, 0, 0, 0);
      chk_all("rst.idle", 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hyper_eot_classifier.md
Name: hyper_eot_classifier

Overview:
- Sits directly downstream of the HyperBus uDMA wrapper's event outputs, in the sys_clk_i domain.
- Records the direction of each issued transfer (RX enable = read, TX enable = write) in an in-order FIFO.
- Pops one entry per end-of-transfer pulse and emits a dedicated read-done or write-done event.
- Replaces the single-flag read/write guess, so back-to-back and overlapping transfers are attributed correctly.

Parameters:
- DEPTH, 4, maximum outstanding transfers tracked; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- sys_clk_i  in  1  system clock; all logic on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous flush of FIFO and counters; error flags are unaffected.
- rx_issue_i  in  1  single-cycle pulse: a read transfer was started (RX channel event).
- tx_issue_i  in  1  single-cycle pulse: a write transfer was started (TX channel event).
- eot_i  in  1  single-cycle pulse: the controller finished one transfer.
- err_clr_i  in  1  clears both sticky error flags.
- rd_done_o  out  1  single-cycle pulse: the oldest outstanding transfer completed and was a read.
- wr_done_o  out  1  single-cycle pulse: the oldest outstanding transfer completed and was a write.
- pending_o  out  CNT_W  number of outstanding entries.
- empty_o  out  1  pending_o == 0.
- full_o  out  1  pending_o == DEPTH.
- err_ovf_o  out  1  sticky: an issue was dropped because the FIFO had no space.
- err_unf_o  out  1  sticky: eot_i arrived with the FIFO empty.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - FIFO pointers and count go to 0.
  - rd_done_o, wr_done_o, err_ovf_o, err_unf_o = 0.
  - empty_o = 1, full_o = 0.
- FIFO storage:
  - 1-bit entries: 1 = read, 0 = write. Write and read pointers wrap modulo DEPTH.
  - Up to two pushes and one pop per cycle.
- Per-cycle evaluation order:
  - 1. Pop: if eot_i=1 and count > 0, pop the head.
  - 2. Pushes: available space = DEPTH − count + (pop ? 1 : 0).
  - 3. rx_issue_i only: push read if space ≥ 1, else drop and set err_ovf_o.
  - 4. tx_issue_i only: same rule, pushing write.
  - 5. Both issue pulses in the same cycle: the read entry is pushed first (older), then the write.
    - space ≥ 2: both pushed.
    - space = 1: read pushed, write dropped, err_ovf_o set.
    - space = 0: both dropped, err_ovf_o set.
- Done outputs are registered, with one cycle latency:
  - If eot_i is popped in cycle N, rd_done_o or wr_done_o pulses in cycle N+1 according to the popped entry.
  - rd_done_o and wr_done_o are never high together.
- Underflow: eot_i with count = 0 produces no done pulse and sets err_unf_o.
  - An issue pulse in that same cycle is still pushed; it is not matched to that eot_i.
- Count arithmetic: count_next = count − pop + pushes_accepted; it never exceeds DEPTH and never wraps.
- pending_o, empty_o and full_o reflect the registered count. They are updated in the same edge as the pointers.
- clr_i:
  - Takes priority over issue and eot on the same cycle; that cycle's inputs are ignored.
  - Pointers and count go to 0; the done outputs are 0 on the next cycle.
- Error flags:
  - err_clr_i clears both flags; its set condition wins if both occur in the same cycle.
  - Flags hold through clr_i.
- No state machine beyond the FIFO. Behaviour is fully defined by pointers, count and flags.
- Reset asserted mid-transfer: everything returns to the reset values immediately; outstanding entries are lost.

Test Plan:
- Single read: rx_issue_i @c0, eot_i @c5 → pending_o=1 for c1..c5, rd_done_o=1 only @c6, wr_done_o stays 0, empty_o=1 @c6.
- Ordered mix: issue R,W,W,R (one per cycle), then 4 eot_i pulses spaced 3 cycles → done sequence rd,wr,wr,rd, each one cycle after its eot_i; pending_o peaks at 4 and full_o=1 with DEPTH=4.
- Simultaneous issues: rx_issue_i=tx_issue_i=1 @c0 with FIFO empty → pending_o=2 @c1; two eot_i pulses → rd_done_o then wr_done_o.
- Overflow: FIFO full (4 entries), then rx_issue_i=tx_issue_i=1 with eot_i=1 in the same cycle → head popped, read pushed, write dropped; pending_o stays 4, err_ovf_o=1; err_clr_i → err_ovf_o=0 next cycle.
- Underflow: eot_i with FIFO empty → no done pulse, err_unf_o=1, pending_o=0.
- Clear and reset: 3 entries pending, clr_i=1 with eot_i=1 → no done pulse, pending_o=0, error flags unchanged. Then 2 issues, drop rstn_i mid-stream → all outputs at reset values asynchronously.
